data_unpack_param: RTL

Parametrised stream unpacker: converts packets of IN_W-bit input words into a continuous stream of OUT_W-bit values, with sop/eop framing, zero-padding of a short final value, and output back-pressure from the downstream consumer. It sits between a word-oriented source (DMA/FIFO) and a narrow sample consumer. It is the next generation of the fixed 32→7 unpacker: widths are generic and downstream `ready_in` is honoured.

---
 rtl/data_unpack_param.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/data_unpack_param.sv
// Stream unpacker: IN_W-bit framed words in, OUT_W-bit values out with back-pressure.
// Define UNPACK_MSB_FIRST_EN to extract values MSB-first (default is LSB-first).
module data_unpack_param #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             ready_out,
    input  logic             valid_in,
    input  logic [IN_W-1:0]  data_in,
    input  logic             sop_in,
    input  logic             eop_in,
    input  logic             ready_in,
    output logic             valid_out,
    output logic [OUT_W-1:0] data_out,
    output logic             sop_out,
    output logic             eop_out,
    output logic             err_out
);

    localparam int BUF_W = IN_W + OUT_W - 1;
    localparam int FW    = $clog2(BUF_W + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PKT  = 1'b1;

    localparam logic [OUT_W-1:0] ONES  = '1;
    localparam logic [FW-1:0]    OUT_F = FW'(OUT_W);
    localparam logic [FW-1:0]    IN_F  = FW'(IN_W);

    logic [0:0]       state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             sop_pend_q, sop_pend_d;
    logic             eop_pend_q, eop_pend_d;
    logic             err_q, err_d;

    logic             last, pop, last_pop, accept, abort;
    logic [BUF_W-1:0] buf_p, load_word, app_word;
    logic [FW-1:0]    fill_p;
    logic [FW:0]      need;
    logic [OUT_W-1:0] head, keep;

    always_comb begin
        valid_out = (fill_q >= OUT_F) || (eop_pend_q && fill_q != '0);
        last      = eop_pend_q && (fill_q <= OUT_F);
        pop       = valid_out && ready_in;
        last_pop  = pop && last;
        fill_p    = (pop && !last) ? fill_q - OUT_F : fill_q;
        need      = {1'b0, fill_p} + (FW+1)'(IN_W);

`ifdef UNPACK_MSB_FIRST_EN
        // Valid bits sit at the top of the buffer; padding lands in the LSBs.
        head      = buf_q[BUF_W-1 -: OUT_W];
        keep      = ~(ONES >> fill_q);
        buf_p     = buf_q << OUT_W;
        load_word = BUF_W'(data_in) << (BUF_W - IN_W);
        app_word  = load_word >> fill_p;
`else
        head      = buf_q[OUT_W-1:0];
        keep      = ~(ONES << fill_q);
        buf_p     = buf_q >> OUT_W;
        load_word = BUF_W'(data_in);
        app_word  = load_word << fill_p;
`endif

        data_out = last ? (head & keep) : head;
        sop_out  = sop_pend_q && valid_out;
        eop_out  = valid_out && last;
        err_out  = err_q;

        if (state_q == S_IDLE) begin
            ready_out = 1'b1;
        end else if (eop_pend_q) begin
            ready_out = last_pop;
        end else begin
            ready_out = (need <= (FW+1)'(BUF_W));
        end

        accept = valid_in && ready_out;
        abort  = (state_q == S_PKT) && !eop_pend_q;
    end

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        fill_d     = fill_q;
        sop_pend_d = sop_pend_q;
        eop_pend_d = eop_pend_q;
        err_d      = 1'b0;

        if (last_pop) begin
            buf_d      = '0;
            fill_d     = '0;
            sop_pend_d = 1'b0;
            eop_pend_d = 1'b0;
            state_d    = S_IDLE;
        end else if (pop) begin
            buf_d      = buf_p;
            fill_d     = fill_p;
            sop_pend_d = 1'b0;
        end

        if (accept) begin
            if (sop_in) begin
                // A sop word always restarts at fill 0, dropping any residue.
                buf_d      = load_word;
                fill_d     = IN_F;
                sop_pend_d = 1'b1;
                eop_pend_d = eop_in;
                state_d    = S_PKT;
                err_d      = abort;
            end else if (abort) begin
                buf_d      = buf_d | app_word;
                fill_d     = fill_p + IN_F;
                eop_pend_d = eop_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            fill_q     <= '0;
            sop_pend_q <= 1'b0;
            eop_pend_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            fill_q     <= fill_d;
            sop_pend_q <= sop_pend_d;
            eop_pend_q <= eop_pend_d;
            err_q      <= err_d;
        end
    end

endmodule
